// File: rtl/vga_sync_receiver_if.sv
// Sync-stream inputs and reconstructed timing outputs of vga_sync_receiver.
// slave: the receiver side; master: the side that drives syncs and observes timing.
interface vga_sync_receiver_if;
  logic       i_HSync;
  logic       i_VSync;
  logic [9:0] o_Col_Count;
  logic [9:0] o_Row_Count;
  logic [9:0] o_Pix_X;
  logic [9:0] o_Pix_Y;
  logic       o_Active;
  logic       o_Frame_Start;
  logic       o_Locked;
  logic       o_Error;

  modport slave (
    input  i_HSync, i_VSync,
    output o_Col_Count, o_Row_Count, o_Pix_X, o_Pix_Y,
    output o_Active, o_Frame_Start, o_Locked, o_Error
  );

  modport master (
    output i_HSync, i_VSync,
    input  o_Col_Count, o_Row_Count, o_Pix_X, o_Pix_Y,
    input  o_Active, o_Frame_Start, o_Locked, o_Error
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// Rebuilds VGA column/row counters from an HSync/VSync pair, validates line/frame length, reports lock.
// Latency: sync fall to counter update 2 clocks; free-running stream, no backpressure.
module vga_sync_receiver #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int LOCK_FRAMES = 2
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  vga_sync_receiver_if.slave bus
);

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0]  LP_MAX      = 10'd1023;
  localparam logic [9:0]  LP_PRE_MAX  = 10'd1022;
  localparam logic [9:0]  LP_LAST_COL = 10'(TOTAL_COLS - 1);
  localparam logic [9:0]  LP_LAST_ROW = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0]  LP_H_OFS    = 10'(H_ACT_START);
  localparam logic [9:0]  LP_V_OFS    = 10'(V_ACT_START);
  localparam logic [10:0] LP_H_LO     = 11'(H_ACT_START);
  localparam logic [10:0] LP_H_HI     = 11'(H_ACT_START + ACTIVE_COLS);
  localparam logic [10:0] LP_V_LO     = 11'(V_ACT_START);
  localparam logic [10:0] LP_V_HI     = 11'(V_ACT_START + ACTIVE_ROWS);
  localparam logic [3:0]  LP_LOCK     = 4'(LOCK_FRAMES);

  logic       r_hsync, r_hsync_d, r_vsync, r_vsync_d;
  logic       r_vpend, r_ferr;
  logic [9:0] r_col, r_row, r_pix_x, r_pix_y;
  logic       r_active, r_frame_start, r_locked, r_error;
  state_t     r_state, w_state_nxt;
  logic [3:0] r_good, w_good_nxt, w_good_inc;

  logic       w_h_fall, w_v_fall, w_frame_start, w_checking;
  logic       w_line_err, w_frame_err, w_timeout, w_err;
  logic [9:0] w_col_nxt, w_row_nxt;
  logic       w_in_win, w_act_nxt;

  assign w_h_fall      = r_hsync_d & ~r_hsync;
  assign w_v_fall      = r_vsync_d & ~r_vsync;
  // A VSync fall coinciding with the HSync fall starts the frame immediately.
  assign w_frame_start = w_h_fall & (r_vpend | w_v_fall);
  assign w_checking    = (r_state != SEARCH);

  assign w_line_err  = w_checking & w_h_fall & (r_col != LP_LAST_COL);
  assign w_frame_err = w_checking & w_frame_start & (r_row != LP_LAST_ROW);
  assign w_timeout   = ~w_h_fall & (r_col == LP_PRE_MAX);
  assign w_err       = w_line_err | w_frame_err | w_timeout;

  assign w_col_nxt = w_h_fall ? 10'd0 : ((r_col == LP_MAX) ? r_col : r_col + 10'd1);
  assign w_row_nxt = w_frame_start ? 10'd0 :
                     ((w_h_fall && r_row != LP_MAX) ? r_row + 10'd1 : r_row);

  // Window decode uses next-cycle counters so outputs line up with o_Col_Count/o_Row_Count.
  assign w_in_win  = ({1'b0, w_col_nxt} >= LP_H_LO) && ({1'b0, w_col_nxt} < LP_H_HI) &&
                     ({1'b0, w_row_nxt} >= LP_V_LO) && ({1'b0, w_row_nxt} < LP_V_HI);
  assign w_act_nxt = (w_state_nxt == LOCKED) && w_in_win;

  assign w_good_inc = r_good + 4'd1;

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good;
    case (r_state)
      SEARCH: begin
        if (w_frame_start) begin
          w_state_nxt = MEASURE;
          w_good_nxt  = 4'd0;
        end
      end
      MEASURE: begin
        if (w_frame_start) begin
          if (w_err || r_ferr) begin
            w_good_nxt = 4'd0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LP_LOCK) w_state_nxt = LOCKED;
          end
        end else if (w_err) begin
          w_good_nxt = 4'd0;
        end
      end
      LOCKED: begin
        if (w_err) begin
          w_state_nxt = MEASURE;
          w_good_nxt  = 4'd0;
        end
      end
      default: begin
        w_state_nxt = SEARCH;
        w_good_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_hsync       <= 1'b1;
      r_hsync_d     <= 1'b1;
      r_vsync       <= 1'b1;
      r_vsync_d     <= 1'b1;
      r_vpend       <= 1'b0;
      r_ferr        <= 1'b0;
      r_col         <= 10'd0;
      r_row         <= 10'd0;
      r_pix_x       <= 10'd0;
      r_pix_y       <= 10'd0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
      r_state       <= SEARCH;
      r_good        <= 4'd0;
    end else begin
      r_hsync       <= bus.i_HSync;
      r_hsync_d     <= r_hsync;
      r_vsync       <= bus.i_VSync;
      r_vsync_d     <= r_vsync;
      r_vpend       <= w_frame_start ? 1'b0 : (r_vpend | w_v_fall);
      // Error memory covers the frame in progress; an error at the boundary belongs to the old frame.
      r_ferr        <= w_frame_start ? 1'b0 : (r_ferr | w_err);
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_pix_x       <= w_act_nxt ? (w_col_nxt - LP_H_OFS) : 10'd0;
      r_pix_y       <= w_act_nxt ? (w_row_nxt - LP_V_OFS) : 10'd0;
      r_active      <= w_act_nxt;
      r_frame_start <= w_frame_start;
      r_locked      <= (w_state_nxt == LOCKED);
      r_error       <= w_err;
      r_state       <= w_state_nxt;
      r_good        <= w_good_nxt;
    end
  end

  assign bus.o_Col_Count   = r_col;
  assign bus.o_Row_Count   = r_row;
  assign bus.o_Pix_X       = r_pix_x;
  assign bus.o_Pix_Y       = r_pix_y;
  assign bus.o_Active      = r_active;
  assign bus.o_Frame_Start = r_frame_start;
  assign bus.o_Locked      = r_locked;
  assign bus.o_Error       = r_error;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Randomized sync streams against a timestamp-based reference model; per-cycle scoreboard of all outputs.
module tb_vga_sync_receiver;

  localparam int TC   = 160;
  localparam int TR   = 16;
  localparam int AC   = 112;
  localparam int AR   = 10;
  localparam int HA   = 36;
  localparam int VA   = 3;
  localparam int LOCK = 2;
  localparam int HS_W = 24;

  typedef struct packed {
    logic [9:0] col;
    logic [9:0] row;
    logic [9:0] px;
    logic [9:0] py;
    logic       act;
    logic       fs;
    logic       lock;
    logic       err;
  } obs_t;

  logic clk;
  logic i_Reset;
  vga_sync_receiver_if bus ();

  vga_sync_receiver #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_ACT_START(HA), .V_ACT_START(VA), .LOCK_FRAMES(LOCK)
  ) dut (
    .i_Clk  (clk),
    .i_Reset(i_Reset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t q[$];
  bit   mon_en = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Model: column is elapsed edges since the last clearing edge; row is HSync falls since frame start.
  int m_n, m_L, m_lines, m_mode, m_good;
  bit m_pend, m_bad, prev_h, prev_v;

  function automatic int sat(input int x);
    return (x > 1023) ? 1023 : x;
  endfunction

  task automatic model_reset();
    m_n = 0; m_L = 0; m_lines = 0; m_mode = 0; m_good = 0;
    m_pend = 0; m_bad = 0; prev_h = 1; prev_v = 1;
  endtask

  task automatic model_edge(input bit hf, input bit vf);
    int   col_pre, row_pre, col, row;
    bit   fs, err, lk, act;
    obs_t e;
    col_pre = sat(m_n - m_L);
    row_pre = sat(m_lines);
    fs  = hf && (m_pend || vf);
    err = 0;
    if (m_mode != 0 && hf && col_pre != TC - 1) err = 1;
    if (m_mode != 0 && fs && row_pre != TR - 1) err = 1;
    if (!hf && (m_n + 1 - m_L) == 1023) err = 1;
    if (hf) m_L = m_n + 1;
    if (fs) begin
      m_lines = 0; m_pend = 0;
    end else begin
      if (hf) m_lines++;
      if (vf) m_pend = 1;
    end
    if (m_mode == 0) begin
      if (fs) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      if (fs) begin
        if (err || m_bad) m_good = 0;
        else m_good++;
        if (m_good == LOCK) m_mode = 2;
      end else if (err) m_good = 0;
    end else if (err) begin
      m_mode = 1; m_good = 0;
    end
    m_bad = fs ? 1'b0 : (m_bad | err);
    m_n++;
    col = sat(m_n - m_L);
    row = sat(m_lines);
    lk  = (m_mode == 2);
    act = lk && col >= HA && col < HA + AC && row >= VA && row < VA + AR;
    e.col  = 10'(col);
    e.row  = 10'(row);
    e.px   = act ? 10'(col - HA) : 10'd0;
    e.py   = act ? 10'(row - VA) : 10'd0;
    e.act  = act;
    e.fs   = fs;
    e.lock = lk;
    e.err  = err;
    q.push_back(e);
  endtask

  function automatic obs_t sample_dut();
    obs_t a;
    a.col  = bus.o_Col_Count;
    a.row  = bus.o_Row_Count;
    a.px   = bus.o_Pix_X;
    a.py   = bus.o_Pix_Y;
    a.act  = bus.o_Active;
    a.fs   = bus.o_Frame_Start;
    a.lock = bus.o_Locked;
    a.err  = bus.o_Error;
    return a;
  endfunction

  always @(posedge clk) begin : monitor
    obs_t a;
    obs_t e;
    #1;
    if (mon_en) begin
      vectors++;
      a = sample_dut();
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow t=%0t: output present but no expected entry", $time);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t: got col=%0d row=%0d x=%0d y=%0d act=%0b fs=%0b lock=%0b err=%0b, want col=%0d row=%0d x=%0d y=%0d act=%0b fs=%0b lock=%0b err=%0b",
                   $time, a.col, a.row, a.px, a.py, a.act, a.fs, a.lock, a.err,
                   e.col, e.row, e.px, e.py, e.act, e.fs, e.lock, e.err);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    obs_t a;
    @(negedge clk);
    mon_en = 1'b0;
    i_Reset = 1'b1;
    bus.i_HSync = 1'b1;
    bus.i_VSync = 1'b1;
    q.delete();
    repeat (cycles) @(negedge clk);
    a = sample_dut();
    vectors++;
    if (a !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs t=%0t: got %h, want all zero", $time, a);
    end
  endtask

  task automatic drive(input bit h, input bit v);
    @(negedge clk);
    if (i_Reset) begin
      i_Reset = 1'b0;
      model_reset();
      model_edge(1'b0, 1'b0);
      mon_en = 1'b1;
    end
    bus.i_HSync = h;
    bus.i_VSync = v;
    model_edge(prev_h & ~h, prev_v & ~v);
    prev_h = h;
    prev_v = v;
  endtask

  // voff lowers VSync that many clocks before the next frame's first HSync fall (0 = coincident).
  task automatic send_frame(input int nlines, input int bad_line, input int bad_len,
                            input int voff, input int max_cyc);
    int cnt;
    int len;
    bit h, v;
    cnt = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      len = (ln == bad_line) ? bad_len : TC;
      for (int c = 0; c < len; c++) begin
        if (max_cyc >= 0 && cnt >= max_cyc) return;
        h = (c >= HS_W);
        v = !((ln < 2) || (voff > 0 && ln == nlines - 1 && c >= len - voff));
        drive(h, v);
        cnt++;
      end
    end
  endtask

  function automatic int rvoff();
    if ($urandom_range(0, 1) == 0) return 0;
    return int'($urandom_range(1, TC - 1));
  endfunction

  initial begin
    int bl;
    i_Reset = 1'b1;
    bus.i_HSync = 1'b1;
    bus.i_VSync = 1'b1;
    model_reset();
    do_reset(3);

    // Acquire lock on a clean stream.
    repeat (4) send_frame(TR, -1, 0, rvoff(), -1);

    // One line a clock short, then recovery.
    send_frame(TR, int'($urandom_range(3, TR - 3)), TC - 1, rvoff(), -1);
    repeat (4) send_frame(TR, -1, 0, rvoff(), -1);

    // Random wrong line length.
    bl = ($urandom_range(0, 1) == 0) ? int'($urandom_range(HS_W + 1, TC - 2))
                                     : int'($urandom_range(TC + 1, TC + 40));
    send_frame(TR, int'($urandom_range(2, TR - 2)), bl, rvoff(), -1);
    repeat (3) send_frame(TR, -1, 0, rvoff(), -1);

    // HSync stuck high: column saturates.
    repeat (1100) drive(1'b1, 1'b1);
    repeat (4) send_frame(TR, -1, 0, rvoff(), -1);

    // Frame one line short.
    send_frame(TR - 1, -1, 0, 0, -1);
    repeat (4) send_frame(TR, -1, 0, rvoff(), -1);

    // Reset in the middle of a frame, then re-acquire.
    send_frame(TR, -1, 0, 0, int'($urandom_range(500, 2000)));
    do_reset(1);
    repeat (2) send_frame(TR, -1, 0, rvoff(), -1);

    @(posedge clk);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
